// File: rtl/xbus_dram_arbiter.sv
// Arbitrates the single SDRAM controller port between CPU xbus, disk DMA and TV scanout,
// sequencing the req/ready/done handshake with a per-transaction watchdog.
module xbus_dram_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned VID_HOLD = 4
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [1:0]  write,
  input  logic [21:0] addr0,
  input  logic [21:0] addr1,
  input  logic [21:0] addr2,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [2:0]  ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [21:0] sdram_addr,
  output logic [31:0] sdram_data_out,
  output logic        sdram_req,
  output logic        sdram_write,
  input  logic        sdram_ready,
  input  logic        sdram_done,
  input  logic [31:0] sdram_data_in,
  output logic [2:0]  grant,
  output logic [3:0]  arb_state
);

  localparam int unsigned WdW = $clog2(TIMEOUT);
  localparam int unsigned VcW = $clog2(VID_HOLD + 1);

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StIssue = 4'b0010,
    StWait  = 4'b0100,
    StAck   = 4'b1000
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       ack_q, ack_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [21:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             sreq_q, sreq_d;
  logic             swr_q, swr_d;
  logic             rr_q, rr_d;
  logic [VcW-1:0]   vid_cnt_q, vid_cnt_d;
  logic [WdW-1:0]   wd_q, wd_d;

  logic [2:0] sel;
  logic       finish;
  logic       expired;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = ack_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sreq_d    = sreq_q;
    swr_d     = swr_q;
    rr_d      = rr_q;
    vid_cnt_d = vid_cnt_q;
    wd_d      = wd_q;

    // Video yields to a pending CPU/DMA request once it has used its burst allowance.
    if (req[2] && ((vid_cnt_q < VcW'(VID_HOLD)) || !(req[0] || req[1]))) begin
      sel = 3'b100;
    end else if (req[0] && req[1]) begin
      sel = rr_q ? 3'b010 : 3'b001;
    end else if (req[0]) begin
      sel = 3'b001;
    end else if (req[1]) begin
      sel = 3'b010;
    end else begin
      sel = 3'b000;
    end

    finish  = ((state_q == StIssue) && sdram_ready && sdram_done) ||
              ((state_q == StWait) && sdram_done);
    expired = (wd_q == WdW'(TIMEOUT - 1));

    unique case (state_q)
      StIdle: begin
        if (sel != 3'b000) begin
          state_d = StIssue;
          grant_d = sel;
          sreq_d  = 1'b1;
          wd_d    = '0;
          if (sel[2]) begin
            addr_d = addr2;
            swr_d  = 1'b0;
            if (vid_cnt_q != VcW'(VID_HOLD)) vid_cnt_d = vid_cnt_q + VcW'(1);
          end else if (sel[1]) begin
            addr_d    = addr1;
            wdata_d   = wdata1;
            swr_d     = write[1];
            rr_d      = 1'b0;
            vid_cnt_d = '0;
          end else begin
            addr_d    = addr0;
            wdata_d   = wdata0;
            swr_d     = write[0];
            rr_d      = 1'b1;
            vid_cnt_d = '0;
          end
        end
      end
      StIssue, StWait: begin
        wd_d = wd_q + WdW'(1);
        if (finish) begin
          state_d = StAck;
          sreq_d  = 1'b0;
          ack_d   = grant_q;
          err_d   = 1'b0;
          if (!swr_q) rdata_d = sdram_data_in;
        end else if (expired) begin
          state_d = StAck;
          sreq_d  = 1'b0;
          ack_d   = grant_q;
          err_d   = 1'b1;
          rdata_d = 32'hffff_ffff;
        end else if ((state_q == StIssue) && sdram_ready) begin
          state_d = StWait;
          sreq_d  = 1'b0;
        end
      end
      StAck: begin
        if ((req & grant_q) == 3'b000) begin
          state_d = StIdle;
          ack_d   = 3'b000;
          err_d   = 1'b0;
          grant_d = 3'b000;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= 3'b000;
      ack_q     <= 3'b000;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sreq_q    <= 1'b0;
      swr_q     <= 1'b0;
      rr_q      <= 1'b0;
      vid_cnt_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sreq_q    <= sreq_d;
      swr_q     <= swr_d;
      rr_q      <= rr_d;
      vid_cnt_q <= vid_cnt_d;
      wd_q      <= wd_d;
    end
  end

  assign ack            = ack_q;
  assign rdata          = rdata_q;
  assign err            = err_q;
  assign sdram_addr     = addr_q;
  assign sdram_data_out = wdata_q;
  assign sdram_req      = sreq_q;
  assign sdram_write    = swr_q;
  assign grant          = grant_q;
  assign arb_state      = state_q;

endmodule

// File: tb/tb_xbus_dram_arbiter.sv
// Bench for xbus_dram_arbiter: vector table of single transactions against an SDRAM model,
// plus hand-written reset and arbitration sequences checked through a scoreboard queue.
module tb_xbus_dram_arbiter;

  localparam int unsigned TO = 16;
  localparam int unsigned VH = 4;
  localparam int MNorm  = 0;
  localparam int MSame  = 1;
  localparam int MNever = 2;

  logic        mclk;
  logic        reset;
  logic [2:0]  req;
  logic [1:0]  write;
  logic [21:0] addr0, addr1, addr2;
  logic [31:0] wdata0, wdata1;
  logic [2:0]  ack;
  logic [31:0] rdata;
  logic        err;
  logic [21:0] sdram_addr;
  logic [31:0] sdram_data_out;
  logic        sdram_req;
  logic        sdram_write;
  logic        sdram_ready;
  logic        sdram_done;
  logic [31:0] sdram_data_in;
  logic [2:0]  grant;
  logic [3:0]  arb_state;

  xbus_dram_arbiter #(.TIMEOUT(TO), .VID_HOLD(VH)) dut (
    .mclk           (mclk),
    .reset          (reset),
    .req            (req),
    .write          (write),
    .addr0          (addr0),
    .addr1          (addr1),
    .addr2          (addr2),
    .wdata0         (wdata0),
    .wdata1         (wdata1),
    .ack            (ack),
    .rdata          (rdata),
    .err            (err),
    .sdram_addr     (sdram_addr),
    .sdram_data_out (sdram_data_out),
    .sdram_req      (sdram_req),
    .sdram_write    (sdram_write),
    .sdram_ready    (sdram_ready),
    .sdram_done     (sdram_done),
    .sdram_data_in  (sdram_data_in),
    .grant          (grant),
    .arb_state      (arb_state)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  // SDRAM model: ready same cycle as request; done next cycle, same cycle, or never.
  int          mode;
  logic        done_pend;
  logic [31:0] mem [0:1023];

  assign sdram_ready   = sdram_req;
  assign sdram_done    = (mode == MSame) ? sdram_req : ((mode == MNorm) ? done_pend : 1'b0);
  assign sdram_data_in = mem[sdram_addr[9:0]];

  always @(posedge mclk) begin
    done_pend <= !reset && sdram_req && sdram_ready;
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= (i == 'h29c) ? 32'hdeadbeef : 32'(i);
    end else if (sdram_done && sdram_write) begin
      mem[sdram_addr[9:0]] <= sdram_data_out;
    end
  end

  typedef struct {
    int          port;
    logic        wr;
    logic [21:0] addr;
    logic [31:0] wdata;
    int          mode;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_one(input vec_t v);
    exp_t ex;
    logic got;
    logic wr_bad;
    int   t0;
    mode   = v.mode;
    write  = 2'b00;
    got    = 1'b0;
    wr_bad = 1'b0;
    case (v.port)
      0: begin addr0 = v.addr; wdata0 = v.wdata; write[0] = v.wr; end
      1: begin addr1 = v.addr; wdata1 = v.wdata; write[1] = v.wr; end
      default: addr2 = v.addr;
    endcase
    sb.push_back('{port: v.port, rdata: v.exp_rdata, err: v.exp_err});
    t0 = cyc;
    req[v.port] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge mclk);
      if (i == 0) begin
        // Post-grant changes on the address/data inputs must not reach the controller.
        addr0  = 22'($urandom);
        addr1  = 22'($urandom);
        addr2  = 22'($urandom);
        wdata0 = $urandom;
        wdata1 = $urandom;
      end
      if (grant != 3'b000 && sdram_write !== v.wr) wr_bad = 1'b1;
      if (ack != 3'b000) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    ex = sb.pop_front();
    chk("ack_port", 32'(ack), 32'(3'b001 << ex.port));
    chk("rdata", rdata, ex.rdata);
    chk("err", 32'(err), 32'(ex.err));
    chk("latency", 32'(cyc - t0), 32'(v.exp_lat));
    chk("sdram_write_hold", 32'(wr_bad), 32'd0);
    req = 3'b000;
    @(negedge mclk);
    chk("back_to_idle", {22'h0, ack, grant, arb_state}, {22'h0, 3'b000, 3'b000, 4'b0001});
  endtask

  // Each port re-requests until it has been served its count; grant order comes from sb.
  task automatic run_seq(input int c0, input int c1, input int c2, input int max_cyc);
    int   rem[3];
    logic drop[3];
    logic oh_bad;
    exp_t ex;
    int   n;
    rem    = '{c0, c1, c2};
    mode   = MNorm;
    write  = 2'b00;
    oh_bad = 1'b0;
    n      = 0;
    for (int p = 0; p < 3; p++) if (rem[p] > 0) req[p] = 1'b1;
    while (sb.size() > 0 && n < max_cyc) begin
      @(negedge mclk);
      n++;
      if (!$onehot0(grant) || !$onehot0(ack)) oh_bad = 1'b1;
      drop = '{1'b0, 1'b0, 1'b0};
      if (ack != 3'b000) begin
        ex = sb.pop_front();
        chk("seq_grant_order", 32'(ack), 32'(3'b001 << ex.port));
        for (int p = 0; p < 3; p++) begin
          if (ack[p]) begin
            req[p]  = 1'b0;
            rem[p]  = rem[p] - 1;
            drop[p] = 1'b1;
          end
        end
      end
      for (int p = 0; p < 3; p++) if (!req[p] && rem[p] > 0 && !drop[p]) req[p] = 1'b1;
    end
    chk("seq_complete", 32'(sb.size()), 32'd0);
    sb.delete();
    chk("seq_onehot", 32'(oh_bad), 32'd0);
    req = 3'b000;
    repeat (2) @(negedge mclk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic ack_bad;
    vecs[0] = '{port: 0, wr: 1'b0, addr: 22'o1234, wdata: 32'h0, mode: MNorm,
                exp_rdata: 32'hdeadbeef, exp_err: 1'b0, exp_lat: 3};
    vecs[1] = '{port: 1, wr: 1'b1, addr: 22'h100, wdata: 32'h12345678, mode: MNorm,
                exp_rdata: 32'hdeadbeef, exp_err: 1'b0, exp_lat: 3};
    vecs[2] = '{port: 2, wr: 1'b0, addr: 22'h100, wdata: 32'h0, mode: MNorm,
                exp_rdata: 32'h12345678, exp_err: 1'b0, exp_lat: 3};
    vecs[3] = '{port: 0, wr: 1'b1, addr: 22'h200, wdata: 32'hcafef00d, mode: MSame,
                exp_rdata: 32'h12345678, exp_err: 1'b0, exp_lat: 2};
    vecs[4] = '{port: 1, wr: 1'b0, addr: 22'h200, wdata: 32'h0, mode: MSame,
                exp_rdata: 32'hcafef00d, exp_err: 1'b0, exp_lat: 2};
    vecs[5] = '{port: 1, wr: 1'b1, addr: 22'h300, wdata: 32'h55aa55aa, mode: MNever,
                exp_rdata: 32'hffffffff, exp_err: 1'b1, exp_lat: int'(TO) + 1};
    vecs[6] = '{port: 0, wr: 1'b0, addr: 22'o1234, wdata: 32'h0, mode: MNorm,
                exp_rdata: 32'hdeadbeef, exp_err: 1'b0, exp_lat: 3};
    vecs[7] = '{port: 1, wr: 1'b0, addr: 22'h300, wdata: 32'h0, mode: MNorm,
                exp_rdata: 32'h00000300, exp_err: 1'b0, exp_lat: 3};
    vecs[8] = '{port: 2, wr: 1'b0, addr: 22'o1234, wdata: 32'h0, mode: MSame,
                exp_rdata: 32'hdeadbeef, exp_err: 1'b0, exp_lat: 2};

    reset = 1'b1;
    req   = 3'b000;
    write = 2'b00;
    addr0 = '0; addr1 = '0; addr2 = '0;
    wdata0 = '0; wdata1 = '0;
    mode  = MNorm;
    repeat (3) @(negedge mclk);
    chk("rst_state", 32'(arb_state), 32'h1);
    chk("rst_grant_ack", {26'h0, grant, ack}, 32'h0);
    chk("rst_err_req_wr", {29'h0, err, sdram_req, sdram_write}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_sdram_addr", 32'(sdram_addr), 32'h0);
    chk("rst_sdram_data", sdram_data_out, 32'h0);
    reset = 1'b0;
    @(negedge mclk);
    chk("idle_no_req", {25'h0, grant, arb_state}, 32'h1);

    foreach (vecs[i]) run_one(vecs[i]);

    // Reset in WAIT abandons the transaction without an ack.
    mode  = MNever;
    addr0 = 22'o1234;
    req   = 3'b001;
    for (int i = 0; i < 10 && arb_state != 4'b0100; i++) @(negedge mclk);
    chk("mid_reach_wait", 32'(arb_state), 32'h4);
    reset = 1'b1;
    req   = 3'b000;
    @(negedge mclk);
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_sdram_req", 32'(sdram_req), 32'h0);
    chk("mid_rst_state", 32'(arb_state), 32'h1);
    chk("mid_rst_rdata", rdata, 32'h0);
    reset   = 1'b0;
    ack_bad = 1'b0;
    if (ack != 3'b000) ack_bad = 1'b1;
    repeat (4) begin
      @(negedge mclk);
      if (ack != 3'b000) ack_bad = 1'b1;
    end
    chk("mid_rst_no_ack", 32'(ack_bad), 32'h0);
    run_one(vecs[0]);

    // Round robin from the reset pointer.
    reset = 1'b1;
    repeat (2) @(negedge mclk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) sb.push_back('{port: k % 2, rdata: 32'h0, err: 1'b0});
    run_seq(4, 4, 0, 200);

    // Video burst limit: four video grants, one CPU grant, then video again.
    sb.push_back('{port: 2, rdata: 32'h0, err: 1'b0});
    sb.push_back('{port: 2, rdata: 32'h0, err: 1'b0});
    sb.push_back('{port: 2, rdata: 32'h0, err: 1'b0});
    sb.push_back('{port: 2, rdata: 32'h0, err: 1'b0});
    sb.push_back('{port: 0, rdata: 32'h0, err: 1'b0});
    sb.push_back('{port: 2, rdata: 32'h0, err: 1'b0});
    run_seq(1, 0, 5, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
